rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite/rd/wd) between two producers: the ALU writeback path and the load/store unit (LSU) return path.
- ALU results are granted directly. Load returns pass through a small FIFO.
- A starvation counter forces LSU priority after a bounded wait.
- Sits between execute/memory stages and the register file; output is registered and drives the register file write port.

Parameters:
- XLEN, 32, data width of write data.
- REG_AW, 5, register index width.
- LSU_DEPTH, 2, LSU FIFO entries; power of 2, minimum 2.
- MAX_WAIT, 3, cycles a non-empty LSU FIFO may be denied before forced LSU priority; minimum 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted when valid && ready.
- alu_rd_i  in  REG_AW  ALU destination register.
- alu_wd_i  in  XLEN  ALU result.
- lsu_valid_i  in  1  load data valid.
- lsu_ready_o  out  1  FIFO can accept; equals FIFO not full.
- lsu_rd_i  in  REG_AW  load destination register.
- lsu_wd_i  in  XLEN  load data.
- regwrite_o  out  1  register file write enable, registered.
- rd_o  out  REG_AW  register file write index, registered.
- wd_o  out  XLEN  register file write data, registered.
- lsu_pending_o  out  $clog2(LSU_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_i==0 at a clock edge):
  - FIFO emptied; contents discarded, including on reset mid-operation.
  - State = ALU_PRI, wait_cnt = 0.
  - regwrite_o = 0, rd_o = 0, wd_o = 0, lsu_pending_o = 0.
  - While reset_i==0: alu_ready_o = 0 and lsu_ready_o = 0.
- FSM states: ALU_PRI, LSU_PRI.
- ALU_PRI:
  - alu_ready_o = 1.
  - If alu_valid_i: grant ALU.
  - Else if FIFO non-empty: grant FIFO head and pop it.
- LSU_PRI:
  - alu_ready_o = 0.
  - If FIFO non-empty: grant FIFO head and pop it.
  - Next state is always ALU_PRI; wait_cnt cleared.
- Starvation counter (wait_cnt):
  - In ALU_PRI, increments each cycle the FIFO is non-empty and its head is not popped.
  - Cleared on any FIFO pop or when the FIFO is empty.
  - When wait_cnt == MAX_WAIT at a clock edge, next state = LSU_PRI.
  - Saturates; never wraps.
- FIFO:
  - Push when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o is derived from the registered count only; no same-cycle pop credit.
  - No bypass: a pushed entry is eligible for grant no earlier than the next cycle.
  - Simultaneous push and pop allowed when not full; count unchanged.
  - Pointers wrap modulo LSU_DEPTH.
- Output register, on grant:
  - rd_o and wd_o load the granted entry.
  - regwrite_o = 1 unless granted rd == 0. An rd==0 entry is consumed with regwrite_o = 0.
  - No grant: regwrite_o = 0; rd_o and wd_o hold their previous values.
- Latency:
  - ALU accept at edge N → regwrite_o high in cycle N+1.
  - LSU push at edge N → earliest regwrite_o in cycle N+2.
- Ordering:
  - Within each port, ordering is preserved.
  - No ordering is guaranteed between ports.
  - Same-rd WAW across ports is the hazard unit's responsibility; the arbiter grants per the rules above.
- Throughput: at most one register file write per cycle.

Decomposition:
- Package rf_wb_pkg:
  - XLEN and REG_AW defaults.
  - Enum wb_state_e {ALU_PRI, LSU_PRI}.
  - Packed struct wb_req_t {rd, wd}.
- Sub-module wb_fifo: synchronous FIFO, parameterised by depth and wb_req_t, with push, pop, full, empty and count.
- Arbiter FSM, starvation counter and output register live in rf_wb_arbiter.

Test Plan:
- ALU only: alu_valid_i=1 with rd=5, wd=0xDEADBEEF at edge N → regwrite_o=1, rd_o=5, wd_o=0xDEADBEEF in cycle N+1; alu_ready_o stays 1.
- LSU only: push rd=7, wd=0x12345678 at edge N → lsu_pending_o=1 in cycle N+1; regwrite_o=1, rd_o=7 in cycle N+2; lsu_pending_o=0.
- Full FIFO: push 2 entries with no pops (ALU valid continuously) → lsu_ready_o=0; a third lsu_valid_i is not accepted and the count stays 2.
- Starvation: FIFO holds rd=9 while ALU is valid every cycle, MAX_WAIT=3 → alu_ready_o=0 for exactly one cycle; rd_o=9 is written the next cycle, then alu_ready_o=1 again.
- rd==0: ALU grant with rd=0, wd=0xFFFFFFFF → regwrite_o=0 next cycle; the ALU handshake still completes.
- Reset mid-operation: FIFO holds 2 entries and reset_i=0 for one edge → lsu_pending_o=0 and regwrite_o=0; no stale write appears afterwards.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// This package is imported by the arbiter top and by its load-return FIFO.
package rf_wb_pkg;

  localparam int DEFAULT_XLEN   = 32;
  localparam int DEFAULT_REG_AW = 5;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LSU_PRI = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [DEFAULT_REG_AW-1:0] rd;
    logic [DEFAULT_XLEN-1:0]   wd;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Synchronous FIFO that holds load returns waiting for the register-file write port.
// DEPTH must be a power of two, so the pointers wrap on their own.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_req_t
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output entry_t                   data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between ALU writeback and queued load returns,
// with a starvation counter that forces one LSU-priority cycle after a bounded wait.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int REG_AW    = DEFAULT_REG_AW,
  parameter int LSU_DEPTH = 2,
  parameter int MAX_WAIT  = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [REG_AW-1:0]            alu_rd_i,
  input  logic [XLEN-1:0]              alu_wd_i,
  input  logic                         lsu_valid_i,
  output logic                         lsu_ready_o,
  input  logic [REG_AW-1:0]            lsu_rd_i,
  input  logic [XLEN-1:0]              lsu_wd_i,
  output logic                         regwrite_o,
  output logic [REG_AW-1:0]            rd_o,
  output logic [XLEN-1:0]              wd_o,
  output logic [$clog2(LSU_DEPTH):0]   lsu_pending_o
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } req_t;

  localparam int WCW = $clog2(MAX_WAIT + 1);

  wb_state_e         state_q, state_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  req_t lsu_req, fifo_head, grant_req;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop, grant;

  assign lsu_req     = '{rd: lsu_rd_i, wd: lsu_wd_i};
  assign lsu_ready_o = reset_i && !fifo_full;
  assign fifo_push   = lsu_valid_i && lsu_ready_o;

  wb_fifo #(
    .DEPTH   (LSU_DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (lsu_req),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (lsu_pending_o)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    regwrite_d  = 1'b0;
    rd_d        = rd_q;
    wd_d        = wd_q;
    alu_ready_o = 1'b0;
    fifo_pop    = 1'b0;
    grant       = 1'b0;
    grant_req   = fifo_head;
    case (state_q)
      ALU_PRI: begin
        alu_ready_o = reset_i;
        if (alu_valid_i) begin
          grant     = 1'b1;
          grant_req = '{rd: alu_rd_i, wd: alu_wd_i};
        end else if (!fifo_empty) begin
          grant    = 1'b1;
          fifo_pop = 1'b1;
        end
        // Count only cycles where a waiting load is passed over; saturate at MAX_WAIT.
        if (fifo_empty || fifo_pop) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
        if (wait_cnt_q == WCW'(MAX_WAIT)) begin
          state_d = LSU_PRI;
        end
      end
      LSU_PRI: begin
        if (!fifo_empty) begin
          grant    = 1'b1;
          fifo_pop = 1'b1;
        end
        wait_cnt_d = '0;
        state_d    = ALU_PRI;
      end
      default: begin
        state_d    = ALU_PRI;
        wait_cnt_d = '0;
      end
    endcase
    // x0 writes are still consumed, just never enabled.
    if (grant) begin
      regwrite_d = (grant_req.rd != '0);
      rd_d       = grant_req.rd;
      wd_d       = grant_req.wd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ALU_PRI;
      wait_cnt_q <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  assign regwrite_o = regwrite_q;
  assign rd_o       = rd_q;
  assign wd_o       = wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int LSU_DEPTH = 2;
  localparam int MAX_WAIT  = 3;
  localparam int CW        = $clog2(LSU_DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [REG_AW-1:0] alu_rd_i;
  logic [XLEN-1:0]   alu_wd_i;
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [XLEN-1:0]   lsu_wd_i;
  logic              regwrite_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   wd_o;
  logic [CW-1:0]     lsu_pending_o;

  int tests_run    = 0;
  int tests_failed = 0;

  rf_wb_arbiter #(
    .XLEN      (XLEN),
    .REG_AW    (REG_AW),
    .LSU_DEPTH (LSU_DEPTH),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .alu_valid_i   (alu_valid_i),
    .alu_ready_o   (alu_ready_o),
    .alu_rd_i      (alu_rd_i),
    .alu_wd_i      (alu_wd_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_wd_i      (lsu_wd_i),
    .regwrite_o    (regwrite_o),
    .rd_o          (rd_o),
    .wd_o          (wd_o),
    .lsu_pending_o (lsu_pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending loads as a queue, a forced-LSU flag and a wait count.
  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } ent_t;

  ent_t              mq[$];
  bit                m_lsu_pri = 1'b0;
  int                m_wait    = 0;
  logic              m_we      = 1'b0;
  logic [REG_AW-1:0] m_rd      = '0;
  logic [XLEN-1:0]   m_wd      = '0;

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    alu_rd_i    = '0;
    alu_wd_i    = '0;
    lsu_valid_i = 1'b0;
    lsu_rd_i    = '0;
    lsu_wd_i    = '0;
  endtask

  // One clock edge; the model advances using the inputs held across the edge.
  task automatic tick();
    bit   ar, lr, granted, popped;
    int   pre_size;
    ent_t g;
    ar       = reset_i && !m_lsu_pri;
    lr       = reset_i && (mq.size() < LSU_DEPTH);
    pre_size = mq.size();
    @(posedge clk_i);
    if (!reset_i) begin
      mq.delete();
      m_lsu_pri = 1'b0;
      m_wait    = 0;
      m_we      = 1'b0;
      m_rd      = '0;
      m_wd      = '0;
    end else begin
      granted = 1'b0;
      popped  = 1'b0;
      if (ar && alu_valid_i) begin
        g.rd    = alu_rd_i;
        g.wd    = alu_wd_i;
        granted = 1'b1;
      end else if (pre_size > 0) begin
        g       = mq.pop_front();
        granted = 1'b1;
        popped  = 1'b1;
      end
      if (granted) begin
        m_we = (g.rd != 0);
        m_rd = g.rd;
        m_wd = g.wd;
      end else begin
        m_we = 1'b0;
      end
      if (lr && lsu_valid_i) mq.push_back('{rd: lsu_rd_i, wd: lsu_wd_i});
      if (m_lsu_pri) begin
        m_lsu_pri = 1'b0;
        m_wait    = 0;
      end else begin
        m_lsu_pri = (m_wait == MAX_WAIT);
        if (popped || pre_size == 0) m_wait = 0;
        else if (m_wait < MAX_WAIT)  m_wait = m_wait + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b0;
    #1;
    tests_run++;
    if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: alu_ready=%b lsu_ready=%b, want 0 0", alu_ready_o, lsu_ready_o);
    end
    tick();
    tick();
    tests_run++;
    if (regwrite_o !== 1'b0 || rd_o !== '0 || wd_o !== '0 || lsu_pending_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: we=%b rd=%0d wd=%h pend=%0d, want all 0", regwrite_o, rd_o, wd_o, lsu_pending_o);
    end
    reset_i = 1'b1;
    #1;
    tests_run++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_ready: alu_ready=%b lsu_ready=%b, want 1 1", alu_ready_o, lsu_ready_o);
    end
  endtask

  task automatic test_alu_only();
    do_reset();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd5;
    alu_wd_i    = 32'hDEADBEEF;
    tick();
    tests_run++;
    if (regwrite_o !== 1'b1 || rd_o !== 5'd5 || wd_o !== 32'hDEADBEEF || alu_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL alu_only: we=%b rd=%0d wd=%h ready=%b, want 1 5 deadbeef 1", regwrite_o, rd_o, wd_o, alu_ready_o);
    end
    idle_inputs();
    tick();
    tests_run++;
    if (regwrite_o !== 1'b0 || rd_o !== 5'd5 || wd_o !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL alu_hold: we=%b rd=%0d wd=%h, want 0 5 deadbeef", regwrite_o, rd_o, wd_o);
    end
  endtask

  task automatic test_lsu_only();
    do_reset();
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd7;
    lsu_wd_i    = 32'h12345678;
    tick();
    idle_inputs();
    tests_run++;
    if (lsu_pending_o !== CW'(1) || regwrite_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lsu_queued: pend=%0d we=%b, want 1 0", lsu_pending_o, regwrite_o);
    end
    tick();
    tests_run++;
    if (regwrite_o !== 1'b1 || rd_o !== 5'd7 || wd_o !== 32'h12345678 || lsu_pending_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL lsu_write: we=%b rd=%0d wd=%h pend=%0d, want 1 7 12345678 0", regwrite_o, rd_o, wd_o, lsu_pending_o);
    end
  endtask

  task automatic test_full_fifo();
    do_reset();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd1;
    alu_wd_i    = 32'h1;
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd10;
    lsu_wd_i    = 32'hA0;
    tick();
    lsu_rd_i = 5'd11;
    lsu_wd_i = 32'hA1;
    tick();
    tests_run++;
    if (lsu_ready_o !== 1'b0 || lsu_pending_o !== CW'(2)) begin
      tests_failed++;
      $display("[TB] FAIL fifo_full: ready=%b pend=%0d, want 0 2", lsu_ready_o, lsu_pending_o);
    end
    lsu_rd_i = 5'd12;
    lsu_wd_i = 32'hA2;
    tick();
    tests_run++;
    if (lsu_pending_o !== CW'(2) || regwrite_o !== 1'b1 || rd_o !== 5'd1) begin
      tests_failed++;
      $display("[TB] FAIL fifo_reject: pend=%0d we=%b rd=%0d, want 2 1 1", lsu_pending_o, regwrite_o, rd_o);
    end
    idle_inputs();
    tick();
    tests_run++;
    if (rd_o !== 5'd10 || wd_o !== 32'hA0 || regwrite_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drain_first: rd=%0d wd=%h we=%b, want 10 a0 1", rd_o, wd_o, regwrite_o);
    end
    tick();
    tests_run++;
    if (rd_o !== 5'd11 || wd_o !== 32'hA1 || regwrite_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drain_second: rd=%0d wd=%h we=%b, want 11 a1 1", rd_o, wd_o, regwrite_o);
    end
    tick();
    tests_run++;
    if (regwrite_o !== 1'b0 || lsu_pending_o !== '0 || rd_o !== 5'd11) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty: we=%b pend=%0d rd=%0d, want 0 0 11", regwrite_o, lsu_pending_o, rd_o);
    end
  endtask

  task automatic test_starvation();
    int low_cnt = 0;
    int low_at  = -1;
    int seen_at = -1;
    do_reset();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd3;
    alu_wd_i    = 32'h33;
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd9;
    lsu_wd_i    = 32'h99;
    tick();
    lsu_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_rd_i = 5'd2;
      alu_wd_i = 32'(i);
      tick();
      if (!alu_ready_o) begin
        low_cnt++;
        low_at = i;
      end
      if (regwrite_o && rd_o == 5'd9 && seen_at < 0) seen_at = i;
    end
    tests_run++;
    if (low_cnt != 1 || low_at != 3) begin
      tests_failed++;
      $display("[TB] FAIL starve_ready_low: cycles=%0d at=%0d, want 1 at 3", low_cnt, low_at);
    end
    tests_run++;
    if (seen_at != 4) begin
      tests_failed++;
      $display("[TB] FAIL starve_write: rd9 written at %0d, want 4", seen_at);
    end
    tests_run++;
    if (alu_ready_o !== 1'b1 || lsu_pending_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL starve_recover: alu_ready=%b pend=%0d, want 1 0", alu_ready_o, lsu_pending_o);
    end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd0;
    alu_wd_i    = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if (alu_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd0_handshake: alu_ready=%b, want 1", alu_ready_o);
    end
    tick();
    tests_run++;
    if (regwrite_o !== 1'b0 || rd_o !== 5'd0 || wd_o !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL rd0_alu: we=%b rd=%0d wd=%h, want 0 0 ffffffff", regwrite_o, rd_o, wd_o);
    end
    idle_inputs();
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd0;
    lsu_wd_i    = 32'h5A5A;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (regwrite_o !== 1'b0 || wd_o !== 32'h5A5A || lsu_pending_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rd0_lsu: we=%b wd=%h pend=%0d, want 0 5a5a 0", regwrite_o, wd_o, lsu_pending_o);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd4;
    alu_wd_i    = 32'h44;
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd20;
    lsu_wd_i    = 32'hB0;
    tick();
    lsu_rd_i = 5'd21;
    tick();
    tests_run++;
    if (lsu_pending_o !== CW'(2)) begin
      tests_failed++;
      $display("[TB] FAIL mid_prefill: pend=%0d, want 2", lsu_pending_o);
    end
    idle_inputs();
    reset_i = 1'b0;
    tick();
    tests_run++;
    if (lsu_pending_o !== '0 || regwrite_o !== 1'b0 || rd_o !== '0 || wd_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: pend=%0d we=%b rd=%0d wd=%h, want 0 0 0 0", lsu_pending_o, regwrite_o, rd_o, wd_o);
    end
    reset_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (regwrite_o !== 1'b0 || lsu_pending_o !== '0) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_stale: %0d cycles showed a write or pending entry, want 0", stale);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      reset_i     = ($urandom_range(0, 59) != 0);
      alu_valid_i = ($urandom_range(0, 99) < 55);
      alu_rd_i    = REG_AW'($urandom_range(0, 31));
      alu_wd_i    = $urandom;
      lsu_valid_i = ($urandom_range(0, 99) < 50);
      lsu_rd_i    = REG_AW'($urandom_range(0, 31));
      lsu_wd_i    = $urandom;
      #1;
      tests_run++;
      if (alu_ready_o !== (reset_i && !m_lsu_pri) || lsu_ready_o !== (reset_i && mq.size() < LSU_DEPTH)
          || lsu_pending_o !== CW'(mq.size())) begin
        tests_failed++;
        bad++;
        if (bad < 10)
          $display("[TB] FAIL rand_ready cyc %0d: alu_ready=%b lsu_ready=%b pend=%0d, want %b %b %0d",
                   i, alu_ready_o, lsu_ready_o, lsu_pending_o, reset_i && !m_lsu_pri,
                   reset_i && mq.size() < LSU_DEPTH, mq.size());
      end
      tick();
      tests_run++;
      if (regwrite_o !== m_we || rd_o !== m_rd || wd_o !== m_wd) begin
        tests_failed++;
        bad++;
        if (bad < 10)
          $display("[TB] FAIL rand_write cyc %0d: we=%b rd=%0d wd=%h, want %b %0d %h",
                   i, regwrite_o, rd_o, wd_o, m_we, m_rd, m_wd);
      end
    end
    reset_i = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b0;
    test_reset();
    test_alu_only();
    test_lsu_only();
    test_full_fifo();
    test_starvation();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
